// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - multi-read-port register file with per-register pending-write scoreboard
// Optional write-through forwarding is enabled by defining RF_BYPASS_EN.
module rf_scoreboard #(
  parameter int DW  = 32,
  parameter int AW  = 5,
  parameter int NRD = 2
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [NRD*AW-1:0] RA,
  output logic [NRD*DW-1:0] RD,
  output logic [NRD-1:0]    Busy,
  input  logic [AW-1:0]     WA,
  input  logic [DW-1:0]     WD,
  input  logic              RFWr,
  input  logic [AW-1:0]     ResvA,
  input  logic              ResvEn
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0]    regs_q [DEPTH];
  logic [DEPTH-1:0] pend_q;
  logic [DEPTH-1:0] pend_d;
  logic             wr_ok;
  logic             resv_ok;

  assign wr_ok   = RFWr && (WA != '0);
  assign resv_ok = ResvEn && (ResvA != '0);

  // Reserve is applied after the write clear so a new producer wins over the completing one.
  always_comb begin
    pend_d = pend_q;
    if (wr_ok)   pend_d[WA]    = 1'b0;
    if (resv_ok) pend_d[ResvA] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      pend_q <= '0;
    end else begin
      if (wr_ok) regs_q[WA] <= WD;
      pend_q <= pend_d;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    logic          bsy;

    assign ra = RA[k*AW +: AW];

    always_comb begin
      rd  = regs_q[ra];
      bsy = pend_q[ra];
`ifdef RF_BYPASS_EN
      if (wr_ok && (ra == WA)) begin
        rd  = WD;
        bsy = resv_ok && (ResvA == WA);
      end
`endif
      if (ra == '0) begin
        rd  = '0;
        bsy = 1'b0;
      end
    end

    assign RD[k*DW +: DW] = rd;
    assign Busy[k]        = bsy;
  end

endmodule

// File: tb/tb_rf_scoreboard.sv
// tb/tb_rf_scoreboard.sv - directed self-checking bench for rf_scoreboard (NRD=4)
module tb_rf_scoreboard;

  logic         Clk = 1'b0;
  logic         Rst;
  logic [19:0]  RA;
  logic [127:0] RD;
  logic [3:0]   Busy;
  logic [4:0]   WA;
  logic [31:0]  WD;
  logic         RFWr;
  logic [4:0]   ResvA;
  logic         ResvEn;

  int checks   = 0;
  int failures = 0;

  rf_scoreboard #(.DW(32), .AW(5), .NRD(4)) dut (
    .Clk(Clk), .Rst(Rst), .RA(RA), .RD(RD), .Busy(Busy),
    .WA(WA), .WD(WD), .RFWr(RFWr), .ResvA(ResvA), .ResvEn(ResvEn)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    RFWr = 1'b0; WA = '0; WD = '0; ResvEn = 1'b0; ResvA = '0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    RFWr = 1'b1; WA = a; WD = d;
    step();
    idle();
  endtask

  task automatic resv(input logic [4:0] a);
    ResvEn = 1'b1; ResvA = a;
    step();
    idle();
  endtask

  task automatic test_reset();
    Rst = 1'b0; RA = '0; idle();
    #1 Rst = 1'b1;
    RA = {5'd4, 5'd3, 5'd2, 5'd1};
    #1;
    checks++;
    if (RD !== 128'h0) begin failures++; $display("FAIL reset_rd got=%h exp=0", RD); end
    checks++;
    if (Busy !== 4'h0) begin failures++; $display("FAIL reset_busy got=%h exp=0", Busy); end
    step();
    Rst = 1'b0;
    wr(5'd5, 32'h1234);
    resv(5'd6);
    RA = {5'd0, 5'd0, 5'd6, 5'd5};
    #1;
    checks++;
    if (RD[31:0] !== 32'h1234) begin failures++; $display("FAIL pre_reset_r5 got=%h exp=00001234", RD[31:0]); end
    checks++;
    if (Busy[1] !== 1'b1) begin failures++; $display("FAIL pre_reset_busy6 got=%b exp=1", Busy[1]); end
    #2 Rst = 1'b1;
    #1;
    checks++;
    if (RD[31:0] !== 32'h0) begin failures++; $display("FAIL async_reset_r5 got=%h exp=0", RD[31:0]); end
    checks++;
    if (Busy !== 4'h0) begin failures++; $display("FAIL async_reset_busy got=%h exp=0", Busy); end
    RFWr = 1'b1; WA = 5'd5; WD = 32'hDEAD;
    step();
    idle();
    Rst = 1'b0;
    #1;
    checks++;
    if (RD[31:0] !== 32'h0) begin failures++; $display("FAIL write_during_reset got=%h exp=0", RD[31:0]); end
  endtask

  task automatic test_zero_reg();
    RFWr = 1'b1; WA = 5'd0; WD = 32'hFFFF_FFFF; ResvEn = 1'b1; ResvA = 5'd0;
    step();
    idle();
    RA = '0;
    #1;
    checks++;
    if (RD !== 128'h0) begin failures++; $display("FAIL zero_reg_rd got=%h exp=0", RD); end
    checks++;
    if (Busy !== 4'h0) begin failures++; $display("FAIL zero_reg_busy got=%h exp=0", Busy); end
  endtask

  task automatic test_reserve_write();
    resv(5'd8);
    RA = {5'd0, 5'd0, 5'd0, 5'd8};
    #1;
    checks++;
    if (Busy[0] !== 1'b1) begin failures++; $display("FAIL resv8_busy got=%b exp=1", Busy[0]); end
    wr(5'd8, 32'hCAFE);
    checks++;
    if (RD[31:0] !== 32'hCAFE) begin failures++; $display("FAIL wr8_rd got=%h exp=0000cafe", RD[31:0]); end
    checks++;
    if (Busy[0] !== 1'b0) begin failures++; $display("FAIL wr8_busy got=%b exp=0", Busy[0]); end
  endtask

  task automatic test_same_edge();
    RFWr = 1'b1; WA = 5'd9; WD = 32'h55; ResvEn = 1'b1; ResvA = 5'd9;
    step();
    idle();
    RA = {5'd0, 5'd0, 5'd0, 5'd9};
    #1;
    checks++;
    if (RD[31:0] !== 32'h55) begin failures++; $display("FAIL same9_rd got=%h exp=00000055", RD[31:0]); end
    checks++;
    if (Busy[0] !== 1'b1) begin failures++; $display("FAIL same9_busy got=%b exp=1", Busy[0]); end
    RFWr = 1'b1; WA = 5'd10; WD = 32'hAA; ResvEn = 1'b1; ResvA = 5'd11;
    step();
    idle();
    RA = {5'd0, 5'd0, 5'd11, 5'd10};
    #1;
    checks++;
    if (RD[31:0] !== 32'hAA) begin failures++; $display("FAIL diff_r10 got=%h exp=000000aa", RD[31:0]); end
    checks++;
    if (Busy[1:0] !== 2'b10) begin failures++; $display("FAIL diff_busy got=%b exp=10", Busy[1:0]); end
    resv(5'd11);
    wr(5'd11, 32'hBB);
    checks++;
    if (Busy[1] !== 1'b0) begin failures++; $display("FAIL rereserve_busy got=%b exp=0", Busy[1]); end
    checks++;
    if (RD[63:32] !== 32'hBB) begin failures++; $display("FAIL rereserve_rd got=%h exp=000000bb", RD[63:32]); end
  endtask

  task automatic test_multi_read();
    wr(5'd3, 32'hA5A5_A5A5);
    RA = {5'd3, 5'd3, 5'd3, 5'd3};
    #1;
    checks++;
    if (RD !== {4{32'hA5A5_A5A5}}) begin failures++; $display("FAIL multi_read got=%h exp=%h", RD, {4{32'hA5A5_A5A5}}); end
    checks++;
    if (Busy !== 4'h0) begin failures++; $display("FAIL multi_busy got=%h exp=0", Busy); end
  endtask

  task automatic test_bypass();
    logic [31:0] exp_rd;
    logic        exp_bsy;
    wr(5'd7, 32'h11);
    resv(5'd7);
    RA = {5'd0, 5'd0, 5'd7, 5'd0};
    RFWr = 1'b1; WA = 5'd7; WD = 32'h77;
    #1;
`ifdef RF_BYPASS_EN
    exp_rd = 32'h77; exp_bsy = 1'b0;
`else
    exp_rd = 32'h11; exp_bsy = 1'b1;
`endif
    checks++;
    if (RD[63:32] !== exp_rd) begin failures++; $display("FAIL bypass_rd got=%h exp=%h", RD[63:32], exp_rd); end
    checks++;
    if (Busy[1] !== exp_bsy) begin failures++; $display("FAIL bypass_busy got=%b exp=%b", Busy[1], exp_bsy); end
    ResvEn = 1'b1; ResvA = 5'd7;
    #1;
    checks++;
    if (Busy[1] !== 1'b1) begin failures++; $display("FAIL bypass_resv_busy got=%b exp=1", Busy[1]); end
    ResvEn = 1'b0; ResvA = 5'd0;
    step();
    idle();
    checks++;
    if (RD[63:32] !== 32'h77) begin failures++; $display("FAIL post_edge_rd got=%h exp=00000077", RD[63:32]); end
    checks++;
    if (Busy[1] !== 1'b0) begin failures++; $display("FAIL post_edge_busy got=%b exp=0", Busy[1]); end
  endtask

  initial begin
    test_reset();
    test_zero_reg();
    test_reserve_write();
    test_same_edge();
    test_multi_read();
    test_bypass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
